// File: rtl/maj_tree_pipe.sv
// maj_tree_pipe: pipelined bitwise majority-of-3 voting tree.
// Each register stage holds one tree level. The mode and the gate node
// (the majority of the last three operands) travel alongside the data.
// A single advance enable moves the whole pipeline forward. It is high
// whenever the output slot is empty or is being consumed.
module maj_tree_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16,
  localparam int N = 3**DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  input  logic               clr,
  output logic [CNT_W-1:0]   tx_count
);

  localparam int NW    = N * WIDTH;
  localparam int MAX_J = N / 3;

  // Stage k (0-based) holds tree level k+1. Only its low 3^(DEPTH-1-k)
  // nodes are meaningful; the upper bits are written as zero.
  logic [NW-1:0]    data_q   [DEPTH];
  logic [1:0]       mode_q   [DEPTH];
  logic [WIDTH-1:0] g_q      [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [NW-1:0]    lvl      [DEPTH];
  logic [NW-1:0]    nxt_data [DEPTH];
  logic [1:0]       nxt_mode [DEPTH];
  logic [WIDTH-1:0] nxt_g    [DEPTH];
  logic [DEPTH-1:0] nxt_vld;
  logic             adv;
  logic [WIDTH-1:0] root;

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_q[DEPTH-1];

  // Select the input of each stage: the operands for stage 0, else the previous stage.
  always_comb begin
    lvl[0]      = in_data;
    nxt_mode[0] = in_mode;
    nxt_vld[0]  = in_valid;
    nxt_g[0]    = maj3(in_data[(N-3)*WIDTH +: WIDTH],
                       in_data[(N-2)*WIDTH +: WIDTH],
                       in_data[(N-1)*WIDTH +: WIDTH]);
    for (int k = 1; k < DEPTH; k++) begin
      lvl[k]      = data_q[k-1];
      nxt_mode[k] = mode_q[k-1];
      nxt_vld[k]  = vld_q[k-1];
      nxt_g[k]    = g_q[k-1];
    end
  end

  // Reduce each level by three to form the next-level nodes.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      nxt_data[k] = '0;
      for (int j = 0; j < MAX_J; j++) begin
        if (j < 3**(DEPTH-1-k)) begin
          nxt_data[k][j*WIDTH +: WIDTH] = maj3(lvl[k][(3*j)*WIDTH   +: WIDTH],
                                               lvl[k][(3*j+1)*WIDTH +: WIDTH],
                                               lvl[k][(3*j+2)*WIDTH +: WIDTH]);
        end
      end
    end
  end

  // Pipeline registers: every stage shifts together on advance and holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q  <= nxt_vld;
      data_q <= nxt_data;
      mode_q <= nxt_mode;
      g_q    <= nxt_g;
    end
  end

  // The output function is decoded from last-stage registers only.
  always_comb begin
    root = data_q[DEPTH-1][WIDTH-1:0];
    case (mode_q[DEPTH-1])
      2'b01:   out_data = root & g_q[DEPTH-1];
      2'b10:   out_data = ~root;
      default: out_data = root;
    endcase
  end

  // Saturating transfer counter. A clear wins over a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_count <= '0;
    end else if (clr) begin
      tx_count <= '0;
    end else if (out_valid && out_ready && (tx_count != {CNT_W{1'b1}})) begin
      tx_count <= tx_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/maj_tree_pipe.md
MAJ_TREE_PIPE -- requirements
Module: maj_tree_pipe

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each voter operand; all voting is bitwise per slice.
REQ-002 Parameter DEPTH, default 2, legal 1..4: number of majority-of-3 tree levels; leaf operand count N = 3^DEPTH.
REQ-003 Parameter CNT_W, default 16: width of the transfer counter.
REQ-004 The block SHALL have one clock and a synchronous active-low reset: clk input, rst_n input.
REQ-005 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-007 Port in_valid, input, 1 bit: in_data/in_mode hold a valid operand set.
REQ-008 Port in_ready, output, 1 bit: block accepts an operand set this cycle.
REQ-009 Port in_data, input, N*WIDTH bits: operand i occupies bits [i*WIDTH +: WIDTH], i = 0..N-1.
REQ-010 Port in_mode, input, 2 bits: output function, captured with the operand set.
REQ-011 Port out_valid, output, 1 bit: out_data holds a result.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 Port out_data, output, WIDTH bits: vote result.
REQ-014 Port clr, input, 1 bit: synchronous clear of tx_count.
REQ-015 Port tx_count, output, CNT_W bits: number of completed output transfers, saturating.

Function
REQ-016 Tree node (L,j), L = 1..DEPTH, SHALL equal bitwise MAJ(a,b,c) = ab|ac|bc of children 3j, 3j+1, 3j+2 of level L-1; level 0 is the operands; root is (DEPTH,0).
REQ-017 Gate node G SHALL be node (1, 3^(DEPTH-1)-1), the majority of the last three operands.
REQ-018 in_mode 00 SHALL give out_data = root; 01 SHALL give root AND G; 10 SHALL give NOT root; 11 SHALL behave as 00.
REQ-019 The pipeline SHALL have DEPTH register stages, one per tree level; the stage-L register holds level-L nodes plus the captured mode and G.
REQ-020 Global advance enable SHALL be adv = out_ready OR NOT out_valid; in_ready SHALL equal adv combinationally.
REQ-021 Input handshake: an operand set is accepted when in_valid AND in_ready.
REQ-022 Output handshake: a transfer occurs when out_valid AND out_ready.
REQ-023 When adv = 1 every stage and its valid bit SHALL shift one level; stage 1 valid SHALL load in_valid.
REQ-024 When adv = 0 all stage registers and valid bits SHALL hold; out_data SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-025 Latency: a set accepted at edge k with adv held high SHALL appear with out_valid = 1 after edge k+DEPTH-1, i.e. on the DEPTH-th clock edge counting the accept edge as the first.
REQ-026 Throughput: one result per cycle while in_valid = 1 and out_ready = 1; ordering SHALL be preserved; no set may be dropped or duplicated.
REQ-027 Bubbles (invalid stages) SHALL propagate under adv and SHALL never raise out_valid.
REQ-028 out_data SHALL be a registered function of the last stage; there SHALL be no combinational path from in_data to out_data.
REQ-029 tx_count SHALL increment by 1 per output transfer and saturate at 2^CNT_W-1.
REQ-030 clr = 1 SHALL set tx_count to 0 on that edge, overriding a same-cycle increment.

Reset
REQ-031 While rst_n = 0 at a clock edge, all stage valid bits, out_valid and tx_count SHALL become 0; data registers are don't-care.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight sets; none SHALL emerge after reset release.
REQ-033 in_ready SHALL be 1 in the first cycle after reset release, since out_valid = 0.

Verification (WIDTH=1, DEPTH=2, CNT_W=4 unless stated)
REQ-034 Mode 01, in_data = 9'b111_000_111 (operands 8..0), out_ready = 1 -> out_data = 1 two edges after accept; in_data = 9'b000_111_111 -> out_data = 0, since root = 1 and G = 0.
REQ-035 Mode 00 and mode 10 with in_data = 9'b011_001_101 -> root = MAJ(1,0,1) = 1; out_data = 1 for mode 00, 0 for mode 10, 1 for mode 11.
REQ-036 Stream of 5 sets with out_ready low for cycles 3-5 -> out_data frozen during the stall, in_ready = 0 while out_valid = 1, all 5 results delivered in order, tx_count = 5.
REQ-037 20 back-to-back transfers with CNT_W = 4 -> tx_count saturates at 15; clr pulsed together with a transfer -> tx_count = 0.
REQ-038 rst_n pulsed low for 1 cycle with 2 sets in flight -> out_valid = 0 afterwards, no stale result, tx_count = 0.
REQ-039 WIDTH = 4, DEPTH = 3, random operands and modes -> every result bitwise-matches a reference tree model, with latency 3.
